// File: rtl/button_conditioner.sv
// Board input front end: two-flop synchronisers for buttons and switches, plus a
// per-button debounce FSM that emits one-cycle press/release strobes and a clean level.
module button_conditioner #(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned NB_SW           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_WIDTH       = 20
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_BTN-1:0] i_btn,
    input  logic [NB_SW-1:0] i_sw,
    output logic [N_BTN-1:0] o_btn_pulse,
    output logic [N_BTN-1:0] o_btn_release,
    output logic [N_BTN-1:0] o_btn_level,
    output logic [NB_SW-1:0] o_sw
);

    typedef enum logic [1:0] {
        S_UP      = 2'd0,
        S_UP_WAIT = 2'd1,
        S_DOWN    = 2'd2,
        S_DN_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] btn_meta;
    logic [N_BTN-1:0] btn_sync;
    logic [NB_SW-1:0] sw_meta;
    logic [NB_SW-1:0] sw_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_meta <= '0;
            btn_sync <= '0;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            btn_meta <= i_btn;
            btn_sync <= btn_meta;
            sw_meta  <= i_sw;
            sw_sync  <= sw_meta;
        end
    end

    assign o_sw = sw_sync;

    for (genvar b = 0; b < N_BTN; b++) begin : g_btn
        state_t               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 pulse_q, pulse_d;
        logic                 release_q, release_d;
        logic                 level_q, level_d;
        logic                 s;

        assign s = btn_sync[b];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_q   <= S_UP;
                cnt_q     <= '0;
                pulse_q   <= 1'b0;
                release_q <= 1'b0;
                level_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                cnt_q     <= cnt_d;
                pulse_q   <= pulse_d;
                release_q <= release_d;
                level_q   <= level_d;
            end
        end

        // Leaving a WAIT state on the terminal count is what keeps cnt from wrapping.
        always_comb begin
            state_d   = state_q;
            cnt_d     = cnt_q;
            pulse_d   = 1'b0;
            release_d = 1'b0;
            level_d   = level_q;
            case (state_q)
                S_UP: begin
                    if (s) begin
                        state_d = S_UP_WAIT;
                        cnt_d   = '0;
                    end
                end
                S_UP_WAIT: begin
                    if (!s) begin
                        state_d = S_UP;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_DOWN;
                        pulse_d = 1'b1;
                        level_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (!s) begin
                        state_d = S_DN_WAIT;
                        cnt_d   = '0;
                    end
                end
                S_DN_WAIT: begin
                    if (s) begin
                        state_d = S_DOWN;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d   = S_UP;
                        release_d = 1'b1;
                        level_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = S_UP;
            endcase
        end

        assign o_btn_pulse[b]   = pulse_q;
        assign o_btn_release[b] = release_q;
        assign o_btn_level[b]   = level_q;
    end

endmodule
